// File: rtl/moore_timed_sequencer_pkg.sv
// Shared types and helpers for the timed Moore phase sequencer.
package moore_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_state_e;

  // Output pattern driven whenever the sequencer is not running.
  localparam int unsigned IDLE_PAT = 0;

  function automatic int unsigned phase_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/moore_timed_sequencer_if.sv
// Control/config/status bundle of the timed sequencer; master drives config, slave is the DUT.
interface moore_timed_sequencer_if
  import moore_seq_pkg::*;
#(
  parameter int unsigned N_PHASE = 4,
  parameter int unsigned OUT_W   = 3,
  parameter int unsigned TIME_W  = 8,
  parameter int unsigned CNT_W   = 8
) ();

  localparam int unsigned PHASE_W = phase_w(N_PHASE);

  logic                      start;
  logic                      stop;
  logic                      mode_loop;
  logic [CNT_W-1:0]          rounds;
  logic [N_PHASE*TIME_W-1:0] dur_flat;
  logic [N_PHASE*OUT_W-1:0]  pat_flat;
  logic [OUT_W-1:0]          out;
  logic [PHASE_W-1:0]        phase;
  logic                      busy;
  logic                      done;
  logic [CNT_W-1:0]          round_cnt;

  modport master (
    output start, stop, mode_loop, rounds, dur_flat, pat_flat,
    input  out, phase, busy, done, round_cnt
  );

  modport slave (
    input  start, stop, mode_loop, rounds, dur_flat, pat_flat,
    output out, phase, busy, done, round_cnt
  );

endinterface

// File: rtl/moore_timed_sequencer_phase_timer.sv
// Per-phase down-counter: load max(dur,1)-1, count down while enabled, tc at zero.
module phase_timer #(
  parameter int unsigned TIME_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [TIME_W-1:0] dur,
  output logic              tc
);

  logic [TIME_W-1:0] cnt_q;

  // A zero duration loads the same value as one, so both last a single cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (dur == '0) ? '0 : dur - TIME_W'(1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TIME_W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/moore_timed_sequencer.sv
// Timed Moore phase sequencer with one-shot/loop modes and a round counter.
// Define SEQ_OUT_REG_EN to add one register stage on out/phase/busy/done.
module moore_timed_sequencer
  import moore_seq_pkg::*;
#(
  parameter int unsigned N_PHASE = 4,
  parameter int unsigned OUT_W   = 3,
  parameter int unsigned TIME_W  = 8,
  parameter int unsigned CNT_W   = 8
) (
  input logic                    clk,
  input logic                    reset,
  moore_timed_sequencer_if.slave bus
);

  localparam int unsigned        PHASE_W    = phase_w(N_PHASE);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(N_PHASE - 1);

  seq_state_e                state_q;
  logic [PHASE_W-1:0]        phase_q;
  logic [CNT_W-1:0]          round_q;
  logic [CNT_W-1:0]          rounds_q;
  logic                      loop_q;
  logic [N_PHASE*TIME_W-1:0] dur_q;
  logic [N_PHASE*OUT_W-1:0]  pat_q;

  logic               tc;
  logic               tmr_load;
  logic               tmr_en;
  logic [TIME_W-1:0]  tmr_dur;
  logic               last_phase;
  logic               last_round;
  logic [PHASE_W-1:0] next_phase;

  assign last_phase = (phase_q == LAST_PHASE);
  assign next_phase = last_phase ? '0 : phase_q + PHASE_W'(1);
  assign last_round = !loop_q && ((round_q + CNT_W'(1)) == rounds_q);

  // In IDLE the timer is primed straight from the input, before config is latched.
  always_comb begin
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_dur  = bus.dur_flat[TIME_W-1:0];
    case (state_q)
      StIdle: tmr_load = bus.start;
      StRun: begin
        tmr_en   = !bus.stop;
        tmr_load = !bus.stop && tc && !(last_phase && last_round);
        tmr_dur  = dur_q[next_phase*TIME_W +: TIME_W];
      end
      default: ;
    endcase
  end

  phase_timer #(
    .TIME_W(TIME_W)
  ) u_phase_timer (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .en   (tmr_en),
    .dur  (tmr_dur),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      round_q  <= '0;
      rounds_q <= '0;
      loop_q   <= 1'b0;
      dur_q    <= '0;
      pat_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            dur_q    <= bus.dur_flat;
            pat_q    <= bus.pat_flat;
            loop_q   <= bus.mode_loop;
            rounds_q <= (bus.rounds == '0) ? CNT_W'(1) : bus.rounds;
            round_q  <= '0;
            phase_q  <= '0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          // Stop wins over a coinciding phase or round end.
          if (bus.stop) begin
            phase_q <= '0;
            state_q <= StIdle;
          end else if (tc) begin
            phase_q <= next_phase;
            if (last_phase) begin
              round_q <= round_q + CNT_W'(1);
              if (last_round) begin
                state_q <= StDone;
              end
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [OUT_W-1:0]   out_c;
  logic [PHASE_W-1:0] phase_c;
  logic               busy_c;
  logic               done_c;

  always_comb begin
    out_c   = OUT_W'(IDLE_PAT);
    phase_c = '0;
    busy_c  = (state_q == StRun);
    done_c  = (state_q == StDone);
    if (busy_c) begin
      out_c   = pat_q[phase_q*OUT_W +: OUT_W];
      phase_c = phase_q;
    end
  end

`ifdef SEQ_OUT_REG_EN
  logic [OUT_W-1:0]   out_q;
  logic [PHASE_W-1:0] phase_out_q;
  logic               busy_q;
  logic               done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      phase_out_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_q       <= out_c;
      phase_out_q <= phase_c;
      busy_q      <= busy_c;
      done_q      <= done_c;
    end
  end

  assign bus.out   = out_q;
  assign bus.phase = phase_out_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
`else
  assign bus.out   = out_c;
  assign bus.phase = phase_c;
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
`endif

  assign bus.round_cnt = round_q;

endmodule

// File: tb/tb_moore_timed_sequencer.sv
// Directed scoreboard bench for moore_timed_sequencer (N_PHASE=4, CNT_W=2).
module tb_moore_timed_sequencer;
  import moore_seq_pkg::*;

  localparam int unsigned N_PHASE = 4;
  localparam int unsigned OUT_W   = 3;
  localparam int unsigned TIME_W  = 8;
  localparam int unsigned CNT_W   = 2;
`ifdef SEQ_OUT_REG_EN
  localparam bit OREG = 1'b1;
`else
  localparam bit OREG = 1'b0;
`endif

  typedef struct packed {
    logic [OUT_W-1:0] out;
    logic [1:0]       phase;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rcnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  moore_timed_sequencer_if #(
    .N_PHASE(N_PHASE), .OUT_W(OUT_W), .TIME_W(TIME_W), .CNT_W(CNT_W)
  ) sif ();

  moore_timed_sequencer #(
    .N_PHASE(N_PHASE), .OUT_W(OUT_W), .TIME_W(TIME_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  exp_t        sb[$];
  exp_t        prev;
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned durs[4];
  int unsigned pats[4];
  string       step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s.%s: observed %0d expected %0d", step, tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input exp_t x);
    chk("out", 32'(sif.out), 32'(x.out));
    chk("phase", 32'(sif.phase), 32'(x.phase));
    chk("busy", 32'(sif.busy), 32'(x.busy));
    chk("done", 32'(sif.done), 32'(x.done));
    chk("round_cnt", 32'(sif.round_cnt), 32'(x.rcnt));
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < 4; i++) begin
      sif.dur_flat[i*TIME_W +: TIME_W] = TIME_W'(durs[i]);
      sif.pat_flat[i*OUT_W +: OUT_W]   = OUT_W'(pats[i]);
    end
  endtask

  // Reference model: one entry per RUN cycle, round_cnt shows rounds completed so far.
  task automatic push_rounds(input int first, input int n);
    for (int r = first; r < first + n; r++) begin
      for (int i = 0; i < 4; i++) begin
        int d;
        d = (durs[i] == 0) ? 1 : int'(durs[i]);
        for (int c = 0; c < d; c++) begin
          sb.push_back('{out: OUT_W'(pats[i]), phase: 2'(i), busy: 1'b1, done: 1'b0,
                         rcnt: CNT_W'(r)});
        end
      end
    end
  endtask

  task automatic push_idle(input logic dn, input int rc);
    sb.push_back('{out: '0, phase: '0, busy: 1'b0, done: dn, rcnt: CNT_W'(rc)});
  endtask

  task automatic drain(input int n);
    exp_t e;
    exp_t x;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL %s.sb_underflow: observed 0 entries expected at least 1", step);
        return;
      end
      e = sb.pop_front();
      x = e;
      if (OREG) begin
        x.out   = prev.out;
        x.phase = prev.phase;
        x.busy  = prev.busy;
        x.done  = prev.done;
      end
      prev = e;
      chk_all(x);
    end
  endtask

  task automatic go(input int rnds, input logic loop);
    sif.rounds    = CNT_W'(rnds);
    sif.mode_loop = loop;
    sif.start     = 1'b1;
    drain(1);
    sif.start = 1'b0;
  endtask

  initial begin
    exp_t z;
    z = '0;
    prev = '0;
    sif.start = 1'b0;
    sif.stop = 1'b0;
    sif.mode_loop = 1'b0;
    sif.rounds = '0;
    durs = '{2, 3, 1, 4};
    pats = '{1, 2, 4, 7};
    apply_cfg();

    step = "reset";
    #12;
    chk_all(z);
    @(negedge clk);
    reset = 1'b1;
    push_idle(1'b0, 0);
    drain(1);

    step = "oneshot_r1";
    push_rounds(0, 1);
    push_idle(1'b1, 1);
    push_idle(1'b0, 1);
    go(1, 1'b0);
    drain(sb.size());

    step = "oneshot_r3";
    push_rounds(0, 3);
    push_idle(1'b1, 3);
    push_idle(1'b0, 3);
    go(3, 1'b0);
    drain(sb.size());

    step = "oneshot_r0";
    push_rounds(0, 1);
    push_idle(1'b1, 1);
    push_idle(1'b0, 1);
    go(0, 1'b0);
    drain(sb.size());

    step = "dur2_zero";
    durs[2] = 0;
    apply_cfg();
    push_rounds(0, 1);
    push_idle(1'b1, 1);
    push_idle(1'b0, 1);
    go(1, 1'b0);
    drain(sb.size());
    durs[2] = 1;
    apply_cfg();

    // Five loop rounds wrap the 2-bit counter; stop lands in phase 0 of round six.
    step = "loop_stop";
    push_rounds(0, 5);
    sb.push_back('{out: OUT_W'(pats[0]), phase: 2'd0, busy: 1'b1, done: 1'b0, rcnt: CNT_W'(1)});
    go(1, 1'b1);
    drain(sb.size());
    sif.stop = 1'b1;
    push_idle(1'b0, 1);
    drain(1);
    sif.stop = 1'b0;
    push_idle(1'b0, 1);
    drain(1);

    step = "stop_at_end";
    push_rounds(0, 1);
    push_idle(1'b0, 0);
    push_idle(1'b0, 0);
    go(1, 1'b0);
    drain(3);
    sif.start = 1'b1;
    drain(1);
    sif.start = 1'b0;
    drain(5);
    sif.stop = 1'b1;
    drain(1);
    sif.stop = 1'b0;
    drain(1);

    step = "reset_mid_run";
    push_rounds(0, 1);
    go(1, 1'b0);
    drain(5);
    #2;
    reset = 1'b0;
    #1;
    chk_all(z);
    sb.delete();
    prev = '0;
    @(negedge clk);
    reset = 1'b1;
    push_idle(1'b0, 0);
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
